// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (common with the ALU-control decoder),
// execute-stage FSM states and serial-shifter modes.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [4:0] ALU_SLTU = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;
  localparam logic [4:0] ALU_NOP  = 5'd31;

  typedef enum logic {IDLE, SHIFT} exec_state_t;

  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_mode_t;

  function automatic logic is_shift_op(input logic [4:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  function automatic shift_mode_t shift_mode_of(input logic [4:0] code);
    shift_mode_t m;
    case (code)
      ALU_SRL: m = SH_RL;
      ALU_SRA: m = SH_RA;
      default: m = SH_LL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter. 'value' is the work register after this cycle's
// step and 'done' says the count reaches zero at the coming edge.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [SHW-1:0]    shamt,
  input  logic [XLEN-1:0]   opA,
  input  shift_mode_t       mode,
  output logic              done,
  output logic [XLEN-1:0]   value
);

  logic [XLEN-1:0] work;
  logic [XLEN-1:0] stepped;
  logic [SHW-1:0]  cnt;
  shift_mode_t     mode_q;

  always_comb begin
    stepped = work;
    case (mode_q)
      SH_LL:   stepped = {work[XLEN-2:0], 1'b0};
      SH_RL:   stepped = {1'b0, work[XLEN-1:1]};
      SH_RA:   stepped = {work[XLEN-1], work[XLEN-1:1]};
      default: stepped = work;
    endcase
  end

  // With cnt at zero the work register simply holds until the result is taken.
  assign value = (cnt != '0) ? stepped : work;
  assign done  = (cnt <= SHW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work   <= '0;
      cnt    <= '0;
      mode_q <= SH_LL;
    end else if (load) begin
      work   <= opA;
      cnt    <= shamt;
      mode_q <= mode;
    end else if (cnt != '0) begin
      work <= stepped;
      cnt  <= cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_execute.sv
// Execute-stage ALU: single-cycle ops load the result register directly;
// nonzero shifts run through the serial shifter while upstream is stalled.
module alu_execute
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [4:0]        aluControl,
  input  logic [XLEN-1:0]   opA,
  input  logic [XLEN-1:0]   opB,
  output logic              outValid,
  input  logic              outReady,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  output logic              busy,
  output exec_state_t       state_dbg
);

  // Handshake: a transfer happens on an edge where valid & ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.

  exec_state_t     state, state_nxt;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  logic            slot_free;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic            shift_start;
  logic            shift_finish;
  logic            load_res;
  logic [XLEN-1:0] alu_val;
  logic [XLEN-1:0] next_result;
  logic            sh_done;
  logic [XLEN-1:0] sh_value;

  assign slot_free    = !out_valid_q || outReady;
  assign inReady      = (state == IDLE) && slot_free;
  assign accept       = inValid && inReady;
  assign shamt        = opB[SHW-1:0];
  assign shift_start  = accept && is_shift_op(aluControl) && (shamt != '0);
  assign shift_finish = (state == SHIFT) && sh_done && slot_free;
  assign load_res     = (accept && !shift_start) || shift_finish;

  // Undefined codes fall to the default and behave as NOP.
  always_comb begin
    alu_val = '0;
    case (aluControl)
      ALU_ADD:  alu_val = opA + opB;
      ALU_SUB:  alu_val = opA - opB;
      ALU_AND:  alu_val = opA & opB;
      ALU_OR:   alu_val = opA | opB;
      ALU_XOR:  alu_val = opA ^ opB;
      ALU_SLT:  alu_val[0] = ($signed(opA) < $signed(opB));
      ALU_SLTU: alu_val[0] = (opA < opB);
      ALU_SLL, ALU_SRL, ALU_SRA: alu_val = opA;
      default:  alu_val = '0;
    endcase
  end

  assign next_result = (state == SHIFT) ? sh_value : alu_val;

  alu_serial_shifter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (shift_start),
    .shamt (shamt),
    .opA   (opA),
    .mode  (shift_mode_of(aluControl)),
    .done  (sh_done),
    .value (sh_value)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (shift_start)  state_nxt = SHIFT;
      SHIFT:   if (shift_finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= load_res || (out_valid_q && !outReady);
      if (load_res) begin
        result_q <= next_result;
        zero_q   <= (next_result == '0);
      end
    end
  end

  assign outValid  = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
